// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bus: hazard sources from the pipeline in, stall/flush
// controls, FSM state, watchdog flag and performance counters out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       D_rs1;
    logic [4:0]       D_rs2;
    logic             D_use_rs1;
    logic             D_use_rs2;
    logic [4:0]       E_rd;
    logic             E_is_load;
    logic             E_reg_we;
    logic             E_jb;
    logic             dmem_req;
    logic             dmem_ready;
    logic             imem_ready;
    logic             clr_cnt;

    logic             stall_pc;
    logic             stall_D;
    logic             flush_D;
    logic             stall_E;
    logic             flush_E;
    logic             stall_M;
    logic             state;
    logic             dwait_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side drives the hazard sources and consumes the controls.
    modport master (
        output D_rs1, D_rs2, D_use_rs1, D_use_rs2, E_rd, E_is_load, E_reg_we,
               E_jb, dmem_req, dmem_ready, imem_ready, clr_cnt,
        input  stall_pc, stall_D, flush_D, stall_E, flush_E, stall_M,
               state, dwait_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  D_rs1, D_rs2, D_use_rs1, D_use_rs2, E_rd, E_is_load, E_reg_we,
               E_jb, dmem_req, dmem_ready, imem_ready, clr_cnt,
        output stall_pc, stall_D, flush_D, stall_E, flush_E, stall_M,
               state, dwait_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: prioritised hazard
// resolution, data-memory wait FSM with watchdog, saturating perf counters.
module hazard_ctrl #(
    parameter int CNT_W     = 32,
    parameter int DWAIT_MAX = 255
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    localparam logic [0:0]  ST_RUN    = 1'b0;
    localparam logic [0:0]  ST_DWAIT  = 1'b1;
    localparam logic [16:0] WAIT_LIM  = 17'(DWAIT_MAX);
    localparam logic [15:0] WAIT_SAT  = 16'hFFFF;

    logic [0:0]       state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic p1_dwait, p2_jb, p3_lu, p4_imem;
    logic waiting;
    logic stall_pc_w;

    always_comb begin
        load_use = bus.E_is_load & bus.E_reg_we & (bus.E_rd != 5'd0) &
                   ((bus.D_use_rs1 & (bus.D_rs1 == bus.E_rd)) |
                    (bus.D_use_rs2 & (bus.D_rs2 == bus.E_rd)));
        // Once in DWAIT the access is outstanding until ready, whatever dmem_req says.
        if (state_q == ST_DWAIT) p1_dwait = ~bus.dmem_ready;
        else                     p1_dwait = bus.dmem_req & ~bus.dmem_ready;
        p2_jb   = ~p1_dwait & bus.E_jb;
        p3_lu   = ~p1_dwait & ~bus.E_jb & load_use;
        p4_imem = ~p1_dwait & ~bus.E_jb & ~load_use & ~bus.imem_ready;
        waiting = (state_q == ST_DWAIT) & ~bus.dmem_ready;
        stall_pc_w = rst & (p1_dwait | p3_lu | p4_imem);
    end

    assign bus.stall_pc      = stall_pc_w;
    assign bus.stall_D       = rst & (p1_dwait | p3_lu);
    assign bus.flush_D       = rst & (p2_jb | p4_imem);
    assign bus.stall_E       = rst & p1_dwait;
    assign bus.flush_E       = rst & (p2_jb | p3_lu);
    assign bus.stall_M       = rst & p1_dwait;
    assign bus.state         = state_q;
    assign bus.dwait_timeout = timeout_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

    always_comb begin
        state_d     = p1_dwait ? ST_DWAIT : ST_RUN;
        wait_d      = 16'd0;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // Watchdog trips on the wait cycle that brings the count to DWAIT_MAX.
        if (waiting) begin
            wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + 16'd1;
            if (({1'b0, wait_q} + 17'd1) >= WAIT_LIM) timeout_d = 1'b1;
        end

        if (bus.clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_pc_w && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (p2_jb && !(&flush_cnt_q))      flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_q      <= 16'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with CNT_W = 4 and DWAIT_MAX = 3.
module tb_hazard_ctrl;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.CNT_W(CNT_W), .DWAIT_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.D_rs1 = 5'd0;      bus.D_rs2 = 5'd0;
        bus.D_use_rs1 = 1'b0;  bus.D_use_rs2 = 1'b0;
        bus.E_rd = 5'd0;       bus.E_is_load = 1'b0;
        bus.E_reg_we = 1'b0;   bus.E_jb = 1'b0;
        bus.dmem_req = 1'b0;   bus.dmem_ready = 1'b0;
        bus.imem_ready = 1'b1; bus.clr_cnt = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the six control outputs: {stall_pc,stall_D,flush_D,stall_E,flush_E,stall_M}
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, bus.stall_pc, bus.stall_D, bus.flush_D,
                  bus.stall_E, bus.flush_E, bus.stall_M}, {26'd0, exp});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle();
        rst = 1'b0;
        bus.imem_ready = 1'b0;
        #1;
        chk_ctl("reset_ctl_gated", 6'b000000);
        tick();
        chk("reset_state", {31'd0, bus.state}, 32'd0);
        chk("reset_timeout", {31'd0, bus.dwait_timeout}, 32'd0);
        chk("reset_stall_cnt", {28'd0, bus.stall_cnt}, 32'd0);
        chk("reset_flush_cnt", {28'd0, bus.flush_cnt}, 32'd0);
        bus.imem_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk_ctl("idle_ctl", 6'b000000);

        // Load-use on rs2: one bubble
        bus.E_is_load = 1'b1; bus.E_reg_we = 1'b1; bus.E_rd = 5'd5;
        bus.D_use_rs2 = 1'b1; bus.D_rs2 = 5'd5;
        #1;
        chk_ctl("lu_rs2_ctl", 6'b110010);
        tick();
        chk("lu_stall_cnt", {28'd0, bus.stall_cnt}, 32'd1);
        bus.E_is_load = 1'b0;
        #1;
        chk_ctl("lu_load_left", 6'b000000);
        bus.E_is_load = 1'b1; bus.E_rd = 5'd0; bus.D_rs2 = 5'd0;
        #1;
        chk_ctl("lu_rd0_ctl", 6'b000000);
        bus.E_rd = 5'd7; bus.D_use_rs2 = 1'b0; bus.D_use_rs1 = 1'b1; bus.D_rs1 = 5'd7;
        #1;
        chk_ctl("lu_rs1_ctl", 6'b110010);
        bus.D_use_rs1 = 1'b0;
        #1;
        chk_ctl("lu_rs1_unused", 6'b000000);
        bus.D_use_rs1 = 1'b1; bus.E_reg_we = 1'b0;
        #1;
        chk_ctl("lu_no_we", 6'b000000);

        // Taken jb overrides load-use and imem
        bus.E_reg_we = 1'b1; bus.E_jb = 1'b1; bus.imem_ready = 1'b0;
        #1;
        chk_ctl("jb_over_lu_ctl", 6'b001010);
        tick();
        chk("jb_flush_cnt", {28'd0, bus.flush_cnt}, 32'd1);
        chk("jb_stall_cnt", {28'd0, bus.stall_cnt}, 32'd1);
        idle();
        bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
        chk("clr_stall_cnt", {28'd0, bus.stall_cnt}, 32'd0);
        chk("clr_flush_cnt", {28'd0, bus.flush_cnt}, 32'd0);

        // Data-memory wait with a taken jb held throughout
        bus.dmem_req = 1'b1; bus.E_jb = 1'b1; bus.imem_ready = 1'b0;
        #1;
        chk_ctl("dw1_ctl", 6'b110101);
        chk("dw1_state", {31'd0, bus.state}, 32'd0);
        tick();
        chk_ctl("dw2_ctl", 6'b110101);
        chk("dw2_state", {31'd0, bus.state}, 32'd1);
        tick();
        bus.dmem_req = 1'b0;
        #1;
        chk_ctl("dw3_noreq_ctl", 6'b110101);
        tick();
        chk("dw3_timeout", {31'd0, bus.dwait_timeout}, 32'd0);
        chk_ctl("dw4_ctl", 6'b110101);
        tick();
        chk("dw4_timeout", {31'd0, bus.dwait_timeout}, 32'd1);
        bus.dmem_ready = 1'b1;
        #1;
        chk("rel_state", {31'd0, bus.state}, 32'd1);
        chk_ctl("rel_ctl", 6'b001010);
        tick();
        chk("rel_state_run", {31'd0, bus.state}, 32'd0);
        chk("rel_flush_cnt", {28'd0, bus.flush_cnt}, 32'd1);
        chk("rel_stall_cnt", {28'd0, bus.stall_cnt}, 32'd4);
        chk("rel_timeout_sticky", {31'd0, bus.dwait_timeout}, 32'd1);
        bus.E_jb = 1'b0; bus.imem_ready = 1'b1;
        #1;
        chk_ctl("post_rel_ctl", 6'b000000);
        tick();
        chk("post_flush_cnt", {28'd0, bus.flush_cnt}, 32'd1);

        // Asynchronous reset mid-wait
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
        tick();
        tick();
        chk("pre_rst_state", {31'd0, bus.state}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", {31'd0, bus.state}, 32'd0);
        chk("arst_timeout", {31'd0, bus.dwait_timeout}, 32'd0);
        chk_ctl("arst_ctl", 6'b000000);
        chk("arst_stall_cnt", {28'd0, bus.stall_cnt}, 32'd0);
        idle();
        #1;
        rst = 1'b1;
        tick();

        // Instruction memory not ready for two cycles
        bus.imem_ready = 1'b0;
        #1;
        chk_ctl("imem1_ctl", 6'b101000);
        tick();
        chk_ctl("imem2_ctl", 6'b101000);
        tick();
        bus.imem_ready = 1'b1;
        chk("imem_stall_cnt", {28'd0, bus.stall_cnt}, 32'd2);
        chk("imem_flush_cnt", {28'd0, bus.flush_cnt}, 32'd0);

        // Saturation then clear together with a stall
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall_cnt", {28'd0, bus.stall_cnt}, 32'd15);
        bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
        chk("clr_with_stall", {28'd0, bus.stall_cnt}, 32'd0);
        tick();
        chk("after_clr_inc", {28'd0, bus.stall_cnt}, 32'd1);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
